// File: rtl/sync_fifo_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_cfg_pkg
//  Brief    : Shared defaults and status bundle for the parametrised sync FIFO
//  Revision : 1.0  initial release
// ============================================================================
package fifo_cfg_pkg;

  localparam int c_DEF_DATA_WIDTH = 16;
  localparam int c_DEF_DEPTH      = 8;

  // Flag snapshot, handy for monitors that compare all status in one go
  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
    logic wr_ack;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param_if
//  Brief    : Producer/consumer bundle of the parametrised sync FIFO
//  Revision : 1.0  initial release
// ============================================================================
interface sync_fifo_param_if
  import fifo_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int DEPTH      = c_DEF_DEPTH
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [c_CW-1:0]       count;

  modport master (
    output wr_en, rd_en, data_in,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  wr_en, rd_en, data_in,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo_param_mem.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_mem
//  Brief    : DEPTH x DATA_WIDTH storage, one write port, one async read port
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_mem
  import fifo_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int DEPTH      = c_DEF_DEPTH
) (
  input  wire logic                       clk,
  input  wire logic                       i_wr_en,
  input  wire logic [$clog2(DEPTH)-1:0]   i_wr_addr,
  input  wire logic [DATA_WIDTH-1:0]      i_wr_data,
  input  wire logic [$clog2(DEPTH)-1:0]   i_rd_addr,
  output logic      [DATA_WIDTH-1:0]      o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // No reset on the array: stale contents are never visible past the pointers
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param
//  Brief    : Single-clock FIFO with thresholds, occupancy and optional FWFT
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_param
  import fifo_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int DEPTH      = c_DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter bit FWFT       = 1'b0
) (
  input wire logic         clk,
  input wire logic         rst_n,
  sync_fifo_param_if.slave bus
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_AF   = c_CW'(AF_THRESH);
  localparam logic [c_CW-1:0] c_CNT_AE   = c_CW'(AE_THRESH);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

  if (DATA_WIDTH < 1) begin : g_chk_width
    $error("sync_fifo_param: DATA_WIDTH must be >= 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH - 1)) begin : g_chk_af
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH-1");
  end
  if ((AE_THRESH < 1) || (AE_THRESH > DEPTH - 1)) begin : g_chk_ae
    $error("sync_fifo_param: AE_THRESH out of range 1..DEPTH-1");
  end

  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_CW-1:0]       r_count;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_go;
  logic                  w_rd_go;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_full  = (r_count == c_CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_wr_go = bus.wr_en & ~w_full;
  assign w_rd_go = bus.rd_en & ~w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_go) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_rd_go) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_wr_go, w_rd_go})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_wr_ack    <= w_wr_go;
      r_overflow  <= bus.wr_en & w_full;
      r_underflow <= bus.rd_en & w_empty;
    end
  end

  // Writes in the reset cycle are dropped so memory matches the pointers
  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_go & rst_n),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.data_in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  if (FWFT) begin : g_fwft
    assign bus.data_out = w_rd_data;
  end else begin : g_reg_out
    logic [DATA_WIDTH-1:0] r_dout;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_dout <= '0;
      end else if (w_rd_go) begin
        r_dout <= w_rd_data;
      end
    end
    assign bus.data_out = r_dout;
  end

  assign bus.wr_ack      = r_wr_ack;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almostfull  = (r_count >= c_CNT_AF) & ~w_full;
  assign bus.almostempty = (r_count <= c_CNT_AE) & ~w_empty;
  assign bus.count       = r_count;

endmodule
`default_nettype wire
